// File: rtl/mpack_watchdog.sv
// Bus watchdog between the CPU packed memory bus and the peripheral decode tree.
// Passes requests/responses through and aborts accesses that stall for TIMEOUT cycles.
module mpack_watchdog #(
  parameter logic [15:0] TIMEOUT   = 16'd255,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [68:0] cpu_fwd,
  output logic [32:0] cpu_ret,
  output logic [68:0] per_fwd,
  input  logic [32:0] per_ret,
  input  logic        err_clr,
  output logic        err_strb,
  output logic [31:0] err_addr,
  output logic        err_wr,
  output logic [15:0] err_cnt
);

  localparam int VALID_BIT = 32;
  localparam int READY_BIT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;
  logic [15:0] err_cnt_q;
  logic        cpu_valid;
  logic        per_ready;
  logic        fire;

  assign cpu_valid = cpu_fwd[VALID_BIT];
  assign per_ready = per_ret[READY_BIT];
  assign cnt_inc   = cnt_q + 16'd1;

  // ABORT is the cycle in which the count has reached TIMEOUT; a ready arriving
  // in that very cycle still wins, so the abort only fires if the access is
  // still pending and unanswered.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    per_fwd  = cpu_fwd;
    cpu_ret  = per_ret;
    err_strb = 1'b0;
    fire     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (TIMEOUT != 16'd0 && cpu_valid && !per_ready) begin
          cnt_d   = 16'd1;
          state_d = (TIMEOUT == 16'd1) ? ABORT : WAIT;
        end
      end

      WAIT: begin
        if (per_ready || !cpu_valid) begin
          cnt_d   = 16'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT) begin
            state_d = ABORT;
          end
        end
      end

      ABORT: begin
        cnt_d = 16'd0;
        if (per_ready || !cpu_valid) begin
          state_d = IDLE;
        end else begin
          fire               = 1'b1;
          err_strb           = 1'b1;
          cpu_ret            = {1'b1, ERR_RDATA};
          per_fwd[VALID_BIT] = 1'b0;
          state_d            = DRAIN;
        end
      end

      DRAIN: begin
        // Hide the abandoned access from peripherals and any late ready from the CPU.
        per_fwd[VALID_BIT] = 1'b0;
        cpu_ret            = '0;
        cnt_d              = 16'd0;
        if (!cpu_valid) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_addr  <= 32'd0;
      err_wr    <= 1'b0;
      err_cnt_q <= 16'd0;
    end else begin
      if (fire) begin
        err_addr <= cpu_fwd[31:0];
        err_wr   <= |cpu_fwd[36:33];
      end
      // A clear coincident with an abort leaves exactly that abort counted.
      if (err_clr) begin
        err_cnt_q <= fire ? 16'd1 : 16'd0;
      end else if (fire && err_cnt_q != 16'hFFFF) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign err_cnt = err_cnt_q;

endmodule
